// File: rtl/hdd_ctrl_pkg.sv
// Shared types and constants for the Apple II HDD request controller.
package hdd_ctrl_pkg;

    localparam int HDD_TMO_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } hdd_state_t;

endpackage

// File: rtl/hdd_req_ctrl_ack_edge.sv
// ack_edge: registers the HPS acknowledge and flags its rising/falling edges.
module ack_edge
    import hdd_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_ack,
    output logic o_rise,
    output logic o_fall
);

    logic r_old_ack;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_old_ack <= 1'b0;
        end else if (i_clr) begin
            r_old_ack <= 1'b0;
        end else begin
            r_old_ack <= i_ack;
        end
    end

    assign o_rise = i_ack & ~r_old_ack;
    assign o_fall = ~i_ack & r_old_ack;

endmodule

// File: rtl/hdd_req_ctrl.sv
// HDD card to HPS channel-1 request controller with CPU stall and mount tracking.
// Optional handshake timeout enabled by defining HDD_TIMEOUT_EN.
module hdd_req_ctrl
    import hdd_ctrl_pkg::*;
#(
    parameter logic [HDD_TMO_W-1:0] TIMEOUT_CYC = 24'd14_000_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        clr,
    input  logic        hdd_read,
    input  logic        hdd_write,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic        img_readonly,
    input  logic        sd_ack,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        cpu_wait,
    output logic        hdd_mounted,
    output logic        hdd_protect,
    output logic        hdd_error,
    output logic        busy
);

    hdd_state_t r_state, w_state_d;
    logic r_rd_pend, w_rd_pend_d;
    logic r_wr_pend, w_wr_pend_d;
    logic r_sd_rd, w_sd_rd_d;
    logic r_sd_wr, w_sd_wr_d;
    logic r_cpu_wait, w_cpu_wait_d;
    logic r_error, w_error_d;
    logic r_mounted, r_protect;
    logic w_rise, w_fall;
    logic w_rd_req, w_wr_req;

`ifdef HDD_TIMEOUT_EN
    logic [HDD_TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_d;
`endif

    ack_edge u_ack_edge (
        .i_clk  (clk_sys),
        .i_rst  (reset),
        .i_clr  (clr),
        .i_ack  (sd_ack),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // A pulse arriving this cycle is serviced directly without a latch round-trip.
    assign w_rd_req = r_rd_pend | hdd_read;
    assign w_wr_req = r_wr_pend | hdd_write;

    always_comb begin
        w_state_d    = r_state;
        w_rd_pend_d  = w_rd_req;
        w_wr_pend_d  = w_wr_req;
        w_sd_rd_d    = r_sd_rd;
        w_sd_wr_d    = r_sd_wr;
        w_cpu_wait_d = r_cpu_wait;
        w_error_d    = r_error;
`ifdef HDD_TIMEOUT_EN
        w_tmo_cnt_d  = r_tmo_cnt + 24'd1;
`endif
        unique case (r_state)
            IDLE: begin
`ifdef HDD_TIMEOUT_EN
                w_tmo_cnt_d = '0;
`endif
                if (w_rd_req) begin
                    w_rd_pend_d = 1'b0;
                    if (!r_mounted) begin
                        w_error_d = 1'b1;
                    end else begin
                        w_error_d    = 1'b0;
                        w_sd_rd_d    = 1'b1;
                        w_cpu_wait_d = 1'b1;
                        w_state_d    = REQ;
                    end
                end else if (w_wr_req) begin
                    w_wr_pend_d = 1'b0;
                    if (!r_mounted || r_protect) begin
                        w_error_d = 1'b1;
                    end else begin
                        w_error_d    = 1'b0;
                        w_sd_wr_d    = 1'b1;
                        w_cpu_wait_d = 1'b1;
                        w_state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (w_rise) begin
                    w_sd_rd_d = 1'b0;
                    w_sd_wr_d = 1'b0;
                    w_state_d = XFER;
`ifdef HDD_TIMEOUT_EN
                    w_tmo_cnt_d = '0;
`endif
                end
            end
            XFER: begin
                if (w_fall) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_cpu_wait_d = 1'b0;
                w_state_d    = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
`ifdef HDD_TIMEOUT_EN
        // Timeout overrides any handshake progress in the same cycle.
        if ((r_state == REQ || r_state == XFER) && r_tmo_cnt == TIMEOUT_CYC - 24'd1) begin
            w_sd_rd_d    = 1'b0;
            w_sd_wr_d    = 1'b0;
            w_cpu_wait_d = 1'b0;
            w_error_d    = 1'b1;
            w_state_d    = IDLE;
        end
`endif
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rd_pend  <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_sd_rd    <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_cpu_wait <= 1'b0;
            r_error    <= 1'b0;
        end else if (clr) begin
            r_state    <= IDLE;
            r_rd_pend  <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_sd_rd    <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_cpu_wait <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_rd_pend  <= w_rd_pend_d;
            r_wr_pend  <= w_wr_pend_d;
            r_sd_rd    <= w_sd_rd_d;
            r_sd_wr    <= w_sd_wr_d;
            r_cpu_wait <= w_cpu_wait_d;
            r_error    <= w_error_d;
        end
    end

`ifdef HDD_TIMEOUT_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (clr) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_d;
        end
    end
`endif

    // Mount state survives clr and updates even mid-transfer.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_mounted <= 1'b0;
            r_protect <= 1'b0;
        end else if (img_mounted) begin
            r_mounted <= (img_size != 64'd0);
            r_protect <= img_readonly;
        end
    end

    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign cpu_wait    = r_cpu_wait;
    assign hdd_error   = r_error;
    assign hdd_mounted = r_mounted;
    assign hdd_protect = r_protect;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_hdd_req_ctrl.sv
// Self-checking bench for hdd_req_ctrl: directed scenarios plus randomized transactions.
module tb_hdd_req_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        clr = 1'b0;
    logic        hdd_read = 1'b0;
    logic        hdd_write = 1'b0;
    logic        img_mounted = 1'b0;
    logic [63:0] img_size = '0;
    logic        img_readonly = 1'b0;
    logic        sd_ack = 1'b0;
    logic        sd_rd, sd_wr, cpu_wait, hdd_mounted, hdd_protect, hdd_error, busy;

    int total = 0;
    int bad = 0;

    // Reference view of mount state and sticky error.
    logic m_mounted = 1'b0;
    logic m_protect = 1'b0;
    logic m_error = 1'b0;

    hdd_req_ctrl #(.TIMEOUT_CYC(24'd16)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .clr          (clr),
        .hdd_read     (hdd_read),
        .hdd_write    (hdd_write),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .img_readonly (img_readonly),
        .sd_ack       (sd_ack),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .cpu_wait     (cpu_wait),
        .hdd_mounted  (hdd_mounted),
        .hdd_protect  (hdd_protect),
        .hdd_error    (hdd_error),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mount(input logic [63:0] size, input logic ro);
        img_mounted  = 1'b1;
        img_size     = size;
        img_readonly = ro;
        tick();
        img_mounted  = 1'b0;
        m_mounted    = (size != 64'd0);
        m_protect    = ro;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({sd_rd, sd_wr, cpu_wait, busy, hdd_error, hdd_mounted, hdd_protect} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {sd_rd, sd_wr, cpu_wait, busy, hdd_error, hdd_mounted, hdd_protect});
        end
        reset = 1'b0;
        tick();
        m_mounted = 1'b0;
        m_protect = 1'b0;
        m_error   = 1'b0;
    endtask

    task automatic test_mounted_read();
        mount(64'h8000, 1'b0);
        total++;
        if (hdd_mounted !== 1'b1 || hdd_protect !== 1'b0) begin
            bad++;
            $display("FAIL mount_flags: got m=%b p=%b want m=1 p=0", hdd_mounted, hdd_protect);
        end
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        total++;
        if ({sd_rd, sd_wr, cpu_wait, busy} !== 4'b1011) begin
            bad++;
            $display("FAIL read_issue: got rd/wr/wait/busy=%b want 1011",
                     {sd_rd, sd_wr, cpu_wait, busy});
        end
        repeat (8) tick();
        total++;
        if (sd_rd !== 1'b1) begin
            bad++;
            $display("FAIL read_hold: got sd_rd=%b want 1", sd_rd);
        end
        sd_ack = 1'b1;
        tick();
        total++;
        if (sd_rd !== 1'b0 || cpu_wait !== 1'b1) begin
            bad++;
            $display("FAIL read_ack_rise: got sd_rd=%b wait=%b want 0 1", sd_rd, cpu_wait);
        end
        repeat (18) tick();
        sd_ack = 1'b0;
        tick();
        total++;
        if (cpu_wait !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL read_done_state: got wait=%b busy=%b want 1 1", cpu_wait, busy);
        end
        tick();
        total++;
        if (cpu_wait !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL read_release: got wait=%b busy=%b want 0 0", cpu_wait, busy);
        end
    endtask

    task automatic test_protected_write();
        logic seen;
        mount(64'h8000, 1'b1);
        hdd_write = 1'b1;
        tick();
        hdd_write = 1'b0;
        total++;
        if (hdd_error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL prot_reject: got err=%b busy=%b want 1 0", hdd_error, busy);
        end
        seen = sd_wr | cpu_wait;
        repeat (4) begin
            tick();
            seen = seen | sd_wr | cpu_wait;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL prot_no_strobe: got wr|wait seen=%b want 0", seen);
        end
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        total++;
        if (hdd_error !== 1'b0 || sd_rd !== 1'b1) begin
            bad++;
            $display("FAIL prot_read_clears: got err=%b sd_rd=%b want 0 1", hdd_error, sd_rd);
        end
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        tick();
        m_error = 1'b0;
    endtask

    task automatic test_simultaneous();
        mount(64'h8000, 1'b0);
        hdd_read  = 1'b1;
        hdd_write = 1'b1;
        tick();
        hdd_read  = 1'b0;
        hdd_write = 1'b0;
        total++;
        if (sd_rd !== 1'b1 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL simul_read_first: got rd=%b wr=%b want 1 0", sd_rd, sd_wr);
        end
        sd_ack = 1'b1;
        repeat (3) tick();
        sd_ack = 1'b0;
        tick();
        total++;
        if (cpu_wait !== 1'b1 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL simul_k1: got wait=%b wr=%b want 1 0", cpu_wait, sd_wr);
        end
        tick();
        total++;
        if (cpu_wait !== 1'b0 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL simul_gap: got wait=%b wr=%b want 0 0", cpu_wait, sd_wr);
        end
        tick();
        total++;
        if (cpu_wait !== 1'b1 || sd_wr !== 1'b1 || sd_rd !== 1'b0) begin
            bad++;
            $display("FAIL simul_write: got wait=%b wr=%b rd=%b want 1 1 0", cpu_wait, sd_wr, sd_rd);
        end
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_unmounted();
        mount(64'h0, 1'b0);
        total++;
        if (hdd_mounted !== 1'b0) begin
            bad++;
            $display("FAIL unmount_flag: got %b want 0", hdd_mounted);
        end
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        total++;
        if (hdd_error !== 1'b1 || busy !== 1'b0 || sd_rd !== 1'b0) begin
            bad++;
            $display("FAIL unmount_reject: got err=%b busy=%b rd=%b want 1 0 0",
                     hdd_error, busy, sd_rd);
        end
        m_error = 1'b1;
    endtask

    task automatic test_abort();
        mount(64'h8000, 1'b0);
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        sd_ack = 1'b1;
        tick();
        // Queue a write while busy; the abort must discard it.
        hdd_write = 1'b1;
        tick();
        hdd_write = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if ({sd_rd, sd_wr, cpu_wait, busy, hdd_error} !== 5'b0 || hdd_mounted !== 1'b1) begin
            bad++;
            $display("FAIL abort_outputs: got %b mounted=%b want 00000 1",
                     {sd_rd, sd_wr, cpu_wait, busy, hdd_error}, hdd_mounted);
        end
        sd_ack = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL abort_late_ack: got busy=%b wr=%b want 0 0", busy, sd_wr);
        end
        repeat (3) tick();
        total++;
        if (busy !== 1'b0 || cpu_wait !== 1'b0 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet: got busy=%b wait=%b wr=%b want 0 0 0",
                     busy, cpu_wait, sd_wr);
        end
        m_error = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            logic is_wr, accept;
            int   dly, hold;
            if ($urandom_range(0, 3) == 0 || it == 0) begin
                logic [63:0] sz;
                sz = ($urandom_range(0, 3) == 0) ? 64'd0 : ({$urandom, $urandom} | 64'd1);
                mount(sz, 1'(($urandom_range(0, 2) == 0)));
            end
            is_wr  = 1'($urandom_range(0, 1));
            accept = m_mounted && !(is_wr && m_protect);
            hdd_read  = ~is_wr;
            hdd_write = is_wr;
            tick();
            hdd_read  = 1'b0;
            hdd_write = 1'b0;
            m_error = ~accept;
            total++;
            if (sd_rd !== (accept & ~is_wr) || sd_wr !== (accept & is_wr) ||
                cpu_wait !== accept || busy !== accept || hdd_error !== m_error) begin
                bad++;
                $display("FAIL rnd_issue[%0d]: got rd=%b wr=%b wait=%b busy=%b err=%b acc=%b wr_op=%b",
                         it, sd_rd, sd_wr, cpu_wait, busy, hdd_error, accept, is_wr);
            end
            if (accept) begin
                dly = $urandom_range(0, 5);
                for (int d = 0; d < dly; d++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        mount(64'h4000, 1'($urandom_range(0, 1)));
                    end else begin
                        tick();
                    end
                end
                total++;
                if ((sd_rd | sd_wr) !== 1'b1 || cpu_wait !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_wait[%0d]: got strobe=%b wait=%b want 1 1",
                             it, sd_rd | sd_wr, cpu_wait);
                end
                hold = $urandom_range(1, 4);
                sd_ack = 1'b1;
                repeat (hold) tick();
                total++;
                if ((sd_rd | sd_wr) !== 1'b0 || cpu_wait !== 1'b1) begin
                    bad++;
                    $display("FAIL rnd_ack[%0d]: got strobe=%b wait=%b want 0 1",
                             it, sd_rd | sd_wr, cpu_wait);
                end
                sd_ack = 1'b0;
                tick();
                tick();
                total++;
                if (cpu_wait !== 1'b0 || busy !== 1'b0 || hdd_error !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_done[%0d]: got wait=%b busy=%b err=%b want 0 0 0",
                             it, cpu_wait, busy, hdd_error);
                end
            end
            total++;
            if (hdd_mounted !== m_mounted || hdd_protect !== m_protect) begin
                bad++;
                $display("FAIL rnd_mount[%0d]: got m=%b p=%b want m=%b p=%b",
                         it, hdd_mounted, hdd_protect, m_mounted, m_protect);
            end
        end
    endtask

`ifdef HDD_TIMEOUT_EN
    task automatic test_timeout();
        logic held;
        mount(64'h8000, 1'b0);
        hdd_read = 1'b1;
        tick();
        hdd_read = 1'b0;
        held = 1'b1;
        repeat (15) begin
            tick();
            held = held & sd_rd & cpu_wait;
        end
        total++;
        if (held !== 1'b1) begin
            bad++;
            $display("FAIL tmo_hold: got held=%b want 1", held);
        end
        tick();
        total++;
        if (sd_rd !== 1'b0 || cpu_wait !== 1'b0 || hdd_error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL tmo_fire: got rd=%b wait=%b err=%b busy=%b want 0 0 1 0",
                     sd_rd, cpu_wait, hdd_error, busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mounted_read();
        test_protected_write();
        test_simultaneous();
        test_unmounted();
        test_abort();
        test_random();
`ifdef HDD_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
